// File: rtl/dmem_ctrl_if.sv
// Memory-side bus between the data-memory controller and its backing RAM.
// The controller takes the master modport, the RAM model takes the slave modport.
interface dmem_ctrl_if #(
  parameter int N  = 64,
  parameter int AW = 10
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_ack;
  logic [N-1:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns pipeline load/store requests into a held
// request/acknowledge transaction on a doubleword-addressed RAM, stalling the pipeline meanwhile.
module dmem_ctrl #(
  parameter int N       = 64,
  parameter int AW      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         stall,
  output logic         misaligned,
  output logic         timeout_err,
  dmem_ctrl_if.master  mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  wdata_q;
  logic          we_q;
  logic [N-1:0]  rdata_q;
  logic [CW-1:0] cnt;

  logic access;
  logic aligned;

  // Address bits above the doubleword index are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^DM_addr[N-1:AW+3];

  assign access  = DM_readEnable | DM_writeEnable;
  assign aligned = (DM_addr[2:0] == 3'b000);

  // NOTE: the outputs below are pure functions of registered state plus the
  // current request; a continuous assign cannot infer a latch.
  assign stall      = ((state == IDLE) && access && aligned) || (state == REQ);
  assign misaligned = (state == IDLE) && access && !aligned && !reset;
  assign DM_readData = misaligned ? '0 : rdata_q;

  assign mem.mem_req   = (state == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // NOTE: every state element uses non-blocking assignment so all registers
  // update together from pre-edge values; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access && aligned) begin
            addr_q  <= DM_addr[AW+2:3];
            wdata_q <= DM_writeData;
            we_q    <= DM_writeEnable;  // store wins when both enables are high
            cnt     <= CW'(1);
            state   <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            if (!we_q) rdata_q <= mem.mem_rdata;
            state <= DONE;
          end else if (cnt == CW'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            rdata_q     <= '0;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus randomized accesses
// checked against a transaction-level model of the read register and error flag.
module tb_dmem_ctrl;
  localparam int N       = 64;
  localparam int AW      = 10;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         DM_writeEnable;
  logic         DM_readEnable;
  logic [N-1:0] DM_readData;
  logic         stall;
  logic         misaligned;
  logic         timeout_err;

  dmem_ctrl_if #(.N(N), .AW(AW)) mem_bus ();

  dmem_ctrl #(.N(N), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .stall          (stall),
    .misaligned     (misaligned),
    .timeout_err    (timeout_err),
    .mem            (mem_bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: what the read register and sticky error flag must hold.
  logic [N-1:0] rdata_model;
  logic         timeout_model;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // One pipeline access from IDLE through DONE. ack_at = REQ cycle (1-based)
  // carrying mem_ack; 0 means the RAM never answers.
  task automatic run_access(input logic [N-1:0] addr, input logic [N-1:0] wd,
                            input logic we, input logic re,
                            input int ack_at, input logic [N-1:0] rd);
    logic [63:0] exp_addr;
    logic        done;
    exp_addr = (addr / 8) % (64'd1 << AW);
    done     = 1'b0;

    @(posedge clk); #1;
    DM_addr = addr; DM_writeData = wd; DM_writeEnable = we; DM_readEnable = re;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = rand64();
    #1;

    if (!(we || re)) begin
      check("noacc_stall", stall, 0);
      check("noacc_req", mem_bus.mem_req, 0);
      check("noacc_misal", misaligned, 0);
      return;
    end

    if (addr % 8 != 0) begin
      check("misal_pulse", misaligned, 1);
      check("misal_stall", stall, 0);
      check("misal_req", mem_bus.mem_req, 0);
      check("misal_rdata", DM_readData, 0);
      @(posedge clk); #1;
      DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
      #1;
      check("misal_one_cycle", misaligned, 0);
      check("misal_no_req", mem_bus.mem_req, 0);
      check("misal_keep_rreg", DM_readData, rdata_model);
      return;
    end

    check("cap_stall", stall, 1);
    check("cap_req", mem_bus.mem_req, 0);
    check("cap_misal", misaligned, 0);

    for (int k = 1; k <= TIMEOUT && !done; k++) begin
      @(posedge clk); #1;
      mem_bus.mem_ack   = (k == ack_at);
      mem_bus.mem_rdata = (k == ack_at) ? rd : rand64();
      #1;
      check("req_req", mem_bus.mem_req, 1);
      check("req_stall", stall, 1);
      check("req_we", mem_bus.mem_we, we);
      check("req_addr", mem_bus.mem_addr, exp_addr);
      check("req_wdata", mem_bus.mem_wdata, wd);
      check("req_rreg", DM_readData, rdata_model);
      if (k == ack_at) begin
        if (!we) rdata_model = rd;
        done = 1'b1;
      end else if (k == TIMEOUT) begin
        timeout_model = 1'b1;
        rdata_model   = '0;
      end
    end

    // DONE: pipeline moves on; a stray ack here must be ignored.
    @(posedge clk); #1;
    DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = rand64();
    #1;
    check("done_stall", stall, 0);
    check("done_req", mem_bus.mem_req, 0);
    check("done_rdata", DM_readData, rdata_model);
    check("done_tmo", timeout_err, timeout_model);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    DM_addr = '0; DM_writeData = '0; DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    rdata_model = '0; timeout_model = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", mem_bus.mem_req, 0);
    check("rst_we", mem_bus.mem_we, 0);
    check("rst_addr", mem_bus.mem_addr, 0);
    check("rst_wdata", mem_bus.mem_wdata, 0);
    check("rst_misal", misaligned, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_rdata", DM_readData, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;

    // Load 0x18, ack on first REQ cycle.
    run_access(64'h18, 64'h0, 1'b0, 1'b1, 1, 64'hDEADBEEF);
    // Store 0x55 to 0x40, ack on fourth REQ cycle; read register unchanged.
    run_access(64'h40, 64'h55, 1'b1, 1'b0, 4, 64'h1234);
    // Misaligned load.
    run_access(64'h1C, 64'h0, 1'b0, 1'b1, 1, 64'h0);
    // Both enables: a single store.
    run_access(64'h8, 64'hA5A5, 1'b1, 1'b1, 2, 64'hBAD);
    // Upper address bits are dropped.
    run_access(64'hFFFF_0000_0000_2008, 64'h0, 1'b0, 1'b1, 3, 64'hCAFE_F00D_0123_4567);
    // Timeout: no ack at all.
    run_access(64'h30, 64'h0, 1'b0, 1'b1, 0, 64'h0);

    // Randomized accesses; the error flag stays sticky throughout.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] a;
      int kind;
      int ack;
      a    = rand64();
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
      kind = $urandom_range(0, 3);
      ack  = (kind >= 2) ? $urandom_range(1, TIMEOUT) : $urandom_range(0, TIMEOUT);
      run_access(a, rand64(), kind >= 2, kind[0], ack, rand64());
    end

    // Reset during the second REQ cycle abandons the access.
    @(posedge clk); #1;
    DM_addr = 64'h48; DM_readEnable = 1'b1; DM_writeEnable = 1'b0; mem_bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rstreq_still_req", mem_bus.mem_req, 1);
    @(posedge clk); #1;
    reset = 1'b0; DM_readEnable = 1'b0;
    #1;
    rdata_model = '0; timeout_model = 1'b0;
    check("rstreq_req", mem_bus.mem_req, 0);
    check("rstreq_stall", stall, 0);
    check("rstreq_tmo", timeout_err, 0);
    check("rstreq_rdata", DM_readData, 0);
    check("rstreq_addr", mem_bus.mem_addr, 0);

    for (int i = 0; i < 10; i++) begin
      logic [N-1:0] a;
      a = {rand64()} & ~64'h7;
      run_access(a, rand64(), 1'b0, 1'b1, $urandom_range(1, TIMEOUT), rand64());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
